// File: rtl/peripheral_timer_sched_ahb3.sv
// AHB3-Lite master that configures the peripheral timer and then re-arms each
// pending channel's TIMECMP by its period on every timer interrupt.
module peripheral_timer_sched_ahb3 #(
  parameter int                    HADDR_SIZE   = 32,
  parameter int                    HDATA_SIZE   = 32,
  parameter int                    TIMERS       = 3,
  parameter logic [HADDR_SIZE-1:0] TIMER_BASE   = '0,
  parameter logic [31:0]           MIN_PRESCALE = 32'd15
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   cfg_start,
  input  logic                   cfg_stop,
  input  logic [31:0]            cfg_prescale,
  input  logic [TIMERS*32-1:0]   cfg_period,
  input  logic [TIMERS-1:0]      cfg_enable,
  input  logic                   tint,
  output logic                   busy,
  output logic [TIMERS-1:0]      tick,
  output logic                   err,
  output logic [HADDR_SIZE-1:0]  HADDR,
  output logic [HDATA_SIZE-1:0]  HWDATA,
  input  logic [HDATA_SIZE-1:0]  HRDATA,
  output logic                   HWRITE,
  output logic [2:0]             HSIZE,
  output logic [2:0]             HBURST,
  output logic [3:0]             HPROT,
  output logic [1:0]             HTRANS,
  input  logic                   HREADY,
  input  logic                   HRESP
);

  localparam int IW = (TIMERS > 1) ? $clog2(TIMERS) : 1;

  typedef enum logic [3:0] {
    IDLE, RD_TLO, RD_THI, WR_CMP, WR_IEN, WR_PRE, WAIT, RD_PEND, REARM, WR_STOP, ERR
  } state_t;

  state_t                 state_q, state_d;
  logic                   dataPhase_q, dataPhase_d;
  logic                   lswHalf_q, lswHalf_d;
  logic [TIMERS-1:0]      workMask_q, workMask_d;
  logic [TIMERS-1:0]      enable_q, enable_d;
  logic [31:0]            prescale_q, prescale_d;
  logic [TIMERS*32-1:0]   period_q, period_d;
  logic [31:0]            tlo_q, tlo_d;
  logic [63:0]            cmp_q [TIMERS];
  logic [63:0]            cmp_d [TIMERS];
  logic [TIMERS-1:0]      tick_q, tick_d;
  logic                   err_q, err_d;
  logic                   stopPend_q, stopPend_d;

  logic                   isBus;
  logic                   badCfg;
  logic [IW-1:0]          idx;
  logic [TIMERS-1:0]      chanBit;
  logic [TIMERS-1:0]      pendNow;
  logic [31:0]            addrOff;

  assign isBus   = state_q inside {RD_TLO, RD_THI, WR_CMP, WR_IEN, WR_PRE, RD_PEND, REARM, WR_STOP};
  assign pendNow = HRDATA[TIMERS-1:0] & enable_q;
  assign busy    = (state_q != IDLE);
  assign tick    = tick_q;
  assign err     = err_q;
  assign HSIZE   = 3'b010;
  assign HBURST  = 3'b000;
  assign HPROT   = 4'b0011;
  assign HTRANS  = (isBus && !dataPhase_q) ? 2'b10 : 2'b00;
  assign HADDR   = TIMER_BASE + HADDR_SIZE'(addrOff);

  // Lowest channel still to be written in the current pass.
  always_comb begin
    idx     = '0;
    chanBit = '0;
    for (int i = TIMERS - 1; i >= 0; i--) begin
      if (workMask_q[i]) idx = IW'(i);
    end
    chanBit[idx] = 1'b1;
  end

  always_comb begin
    badCfg = (cfg_prescale < MIN_PRESCALE) || (cfg_enable == '0);
    for (int i = 0; i < TIMERS; i++) begin
      if (cfg_enable[i] && (cfg_period[32*i +: 32] == 32'h0)) badCfg = 1'b1;
    end
  end

  always_comb begin
    addrOff = 32'h0;
    HWDATA  = '0;
    HWRITE  = 1'b0;
    case (state_q)
      RD_TLO:  addrOff = 32'h10;
      RD_THI:  addrOff = 32'h14;
      WR_CMP, REARM: begin
        HWRITE  = 1'b1;
        addrOff = 32'h18 + 32'(idx) * 32'h10 + (lswHalf_q ? 32'h0 : 32'h4);
        HWDATA  = lswHalf_q ? HDATA_SIZE'(cmp_q[idx][31:0]) : HDATA_SIZE'(cmp_q[idx][63:32]);
      end
      WR_IEN: begin
        HWRITE  = 1'b1;
        addrOff = 32'hC;
        HWDATA  = HDATA_SIZE'(enable_q);
      end
      WR_PRE: begin
        HWRITE  = 1'b1;
        addrOff = 32'h0;
        HWDATA  = HDATA_SIZE'(prescale_q);
      end
      RD_PEND: addrOff = 32'h8;
      WR_STOP: begin
        HWRITE  = 1'b1;
        addrOff = 32'hC;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    dataPhase_d = dataPhase_q;
    lswHalf_d   = lswHalf_q;
    workMask_d  = workMask_q;
    enable_d    = enable_q;
    prescale_d  = prescale_q;
    period_d    = period_q;
    tlo_d       = tlo_q;
    cmp_d       = cmp_q;
    tick_d      = '0;
    err_d       = err_q;
    stopPend_d  = stopPend_q;

    // A stop request outside WAIT is remembered until WAIT is reached.
    if (cfg_stop && (state_q != IDLE) && (state_q != ERR)) stopPend_d = 1'b1;

    if (isBus) begin
      if (!dataPhase_q) begin
        dataPhase_d = 1'b1;
      end else if (HREADY) begin
        dataPhase_d = 1'b0;
        if (HRESP) begin
          state_d    = ERR;
          err_d      = 1'b1;
          stopPend_d = 1'b0;
        end else begin
          case (state_q)
            RD_TLO: begin
              tlo_d   = HRDATA[31:0];
              state_d = RD_THI;
            end
            RD_THI: begin
              for (int i = 0; i < TIMERS; i++) begin
                if (enable_q[i]) cmp_d[i] = {HRDATA[31:0], tlo_q} + 64'(period_q[32*i +: 32]);
              end
              workMask_d = enable_q;
              lswHalf_d  = 1'b0;
              state_d    = WR_CMP;
            end
            WR_CMP, REARM: begin
              if (!lswHalf_q) begin
                lswHalf_d = 1'b1;
              end else begin
                lswHalf_d  = 1'b0;
                workMask_d = workMask_q & ~chanBit;
                if (state_q == REARM) tick_d = chanBit;
                if ((workMask_q & ~chanBit) == '0) state_d = (state_q == WR_CMP) ? WR_IEN : WAIT;
              end
            end
            WR_IEN:  state_d = WR_PRE;
            WR_PRE:  state_d = WAIT;
            RD_PEND: begin
              if (pendNow == '0) begin
                state_d = WAIT;
              end else begin
                for (int i = 0; i < TIMERS; i++) begin
                  if (pendNow[i]) cmp_d[i] = cmp_q[i] + 64'(period_q[32*i +: 32]);
                end
                workMask_d = pendNow;
                lswHalf_d  = 1'b0;
                state_d    = REARM;
              end
            end
            WR_STOP: begin
              state_d    = IDLE;
              stopPend_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
    end else begin
      case (state_q)
        IDLE, ERR: begin
          if (cfg_start) begin
            stopPend_d = 1'b0;
            if (badCfg) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else begin
              err_d       = 1'b0;
              enable_d    = cfg_enable;
              prescale_d  = cfg_prescale;
              period_d    = cfg_period;
              dataPhase_d = 1'b0;
              lswHalf_d   = 1'b0;
              state_d     = RD_TLO;
            end
          end
        end
        WAIT: begin
          if (stopPend_q || cfg_stop) begin
            stopPend_d = 1'b0;
            state_d    = WR_STOP;
          end else if (tint) begin
            state_d = RD_PEND;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= IDLE;
      dataPhase_q <= 1'b0;
      lswHalf_q   <= 1'b0;
      workMask_q  <= '0;
      enable_q    <= '0;
      prescale_q  <= '0;
      period_q    <= '0;
      tlo_q       <= '0;
      for (int i = 0; i < TIMERS; i++) cmp_q[i] <= '0;
      tick_q      <= '0;
      err_q       <= 1'b0;
      stopPend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dataPhase_q <= dataPhase_d;
      lswHalf_q   <= lswHalf_d;
      workMask_q  <= workMask_d;
      enable_q    <= enable_d;
      prescale_q  <= prescale_d;
      period_q    <= period_d;
      tlo_q       <= tlo_d;
      cmp_q       <= cmp_d;
      tick_q      <= tick_d;
      err_q       <= err_d;
      stopPend_q  <= stopPend_d;
    end
  end

endmodule

// File: tb/tb_peripheral_timer_sched_ahb3.sv
// Scoreboard bench: an AHB slave model reports completed transfers, a monitor
// matches them and the tick pulses against a queue filled from a timer model.
module tb_peripheral_timer_sched_ahb3;

  localparam int TIMERS = 3;

  logic                 HCLK = 1'b0;
  logic                 HRESET;
  logic                 cfg_start, cfg_stop, tint;
  logic [31:0]          cfg_prescale;
  logic [TIMERS*32-1:0] cfg_period;
  logic [TIMERS-1:0]    cfg_enable;
  logic                 busy, err;
  logic [TIMERS-1:0]    tick;
  logic [31:0]          HADDR, HWDATA, HRDATA;
  logic                 HWRITE, HREADY, HRESP;
  logic [2:0]           HSIZE, HBURST;
  logic [3:0]           HPROT;
  logic [1:0]           HTRANS;

  peripheral_timer_sched_ahb3 #(.TIMERS(TIMERS)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_prescale(cfg_prescale), .cfg_period(cfg_period), .cfg_enable(cfg_enable),
    .tint(tint), .busy(busy), .tick(tick), .err(err), .HADDR(HADDR), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    int          kind;   // 0 = bus transfer, 1 = tick pulse
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          doneCyc = 0;
  int          ipendReads = 0;
  int          waitMax = 0;
  int          waitFixed = -1;
  logic [63:0] timeVal = '0;
  logic [31:0] pendReg = '0;
  logic [31:0] errAddr = '0;
  bit          errArm = 1'b0;
  logic [31:0] obsAddr, obsData;
  logic        obsWr;
  event        xferEv;

  logic [63:0]       mCmp [TIMERS];
  logic [31:0]       mPeriod [TIMERS];
  logic [TIMERS-1:0] mEnable;
  logic [31:0]       mPrescale;

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic pushBus(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    expQ.push_back('{0, wr, addr, data});
  endtask

  task automatic pushTick(input int n);
    expQ.push_back('{1, 1'b0, 32'(n), 32'h0});
  endtask

  // Timer slave: random or fixed wait states, optional one-shot error response.
  initial begin
    logic [31:0] a, d;
    logic        w;
    int          nWait;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    forever begin
      @(posedge HCLK); #1;
      HREADY = 1'b1; HRESP = 1'b0;
      if (HTRANS == 2'b10 && !HRESET) begin
        a = HADDR; w = HWRITE;
        @(posedge HCLK); #1;
        d = HWDATA;
        nWait = (waitFixed >= 0) ? waitFixed : $urandom_range(0, waitMax);
        for (int k = 0; k < nWait; k++) begin
          HREADY = 1'b0;
          @(posedge HCLK); #1;
          if (!HRESET) begin
            checkOutput("hold_haddr", 64'(HADDR), 64'(a));
            checkOutput("hold_hwdata", 64'(HWDATA), 64'(d));
          end
        end
        HREADY = 1'b1;
        case (a)
          32'h10:  HRDATA = timeVal[31:0];
          32'h14:  HRDATA = timeVal[63:32];
          32'h08:  HRDATA = pendReg;
          default: HRDATA = 32'h0;
        endcase
        if (w && errArm && a == errAddr) begin
          HRESP  = 1'b1;
          errArm = 1'b0;
        end
        if (a == 32'h8 && !w) ipendReads++;
        if (!HRESET) begin
          obsAddr = a; obsWr = w; obsData = d; doneCyc = cyc;
          ->xferEv;
        end
      end
    end
  end

  // Bus monitor: every completed transfer must match the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(xferEv);
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL bus_unexpected: got wr=%0b addr=%h data=%h, expected none", obsWr, obsAddr, obsData);
      end else begin
        e = expQ.pop_front();
        if (e.kind != 0 || e.wr != obsWr || e.addr != obsAddr || (e.wr && e.data != obsData)) begin
          errors++;
          $display("[TB] FAIL bus_xfer: got wr=%0b addr=%h data=%h, expected kind=%0d wr=%0b addr=%h data=%h",
                   obsWr, obsAddr, obsData, e.kind, e.wr, e.addr, e.data);
        end
      end
    end
  end

  // Tick monitor: a tick must follow its LSW write by exactly one cycle.
  initial begin
    exp_t e;
    logic [TIMERS-1:0] want;
    forever begin
      @(negedge HCLK);
      if (tick !== '0) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL tick_unexpected: got %b, expected none", tick);
        end else begin
          e = expQ.pop_front();
          want = '0;
          if (e.kind == 1) want[e.addr[1:0]] = 1'b1;
          if (e.kind != 1 || tick !== want || cyc != doneCyc + 1) begin
            errors++;
            $display("[TB] FAIL tick: got %b at cycle %0d, expected %b at cycle %0d (kind %0d)",
                     tick, cyc, want, doneCyc + 1, e.kind);
          end
        end
      end
    end
  end

  task automatic waitDrain(input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(negedge HCLK);
      n++;
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d items outstanding, expected 0", expQ.size());
      expQ.delete();
    end
    repeat (4) @(negedge HCLK);
  endtask

  // Drive a configuration; when it is valid, queue the expected bus sequence.
  task automatic applyStimulus(input logic [63:0] t, input bit good, input bit skipPre);
    @(negedge HCLK);
    timeVal      = t;
    cfg_prescale = mPrescale;
    cfg_enable   = mEnable;
    for (int n = 0; n < TIMERS; n++) cfg_period[32*n +: 32] = mPeriod[n];
    if (good) begin
      pushBus(1'b0, 32'h10, 32'h0);
      pushBus(1'b0, 32'h14, 32'h0);
      for (int n = 0; n < TIMERS; n++) begin
        if (mEnable[n]) begin
          mCmp[n] = t + 64'(mPeriod[n]);
          pushBus(1'b1, 32'h1C + 32'(16*n), mCmp[n][63:32]);
          pushBus(1'b1, 32'h18 + 32'(16*n), mCmp[n][31:0]);
        end
      end
      pushBus(1'b1, 32'hC, 32'(mEnable));
      if (!skipPre) pushBus(1'b1, 32'h0, mPrescale);
    end
    cfg_start = 1'b1;
    @(negedge HCLK);
    cfg_start = 1'b0;
  endtask

  task automatic serviceIrq(input logic [TIMERS-1:0] pend, input bit stopMid);
    logic [TIMERS-1:0] p;
    int start, k;
    p = pend & mEnable;
    pushBus(1'b0, 32'h8, 32'h0);
    for (int n = 0; n < TIMERS; n++) begin
      if (p[n]) begin
        mCmp[n] = mCmp[n] + 64'(mPeriod[n]);
        pushBus(1'b1, 32'h1C + 32'(16*n), mCmp[n][63:32]);
        pushBus(1'b1, 32'h18 + 32'(16*n), mCmp[n][31:0]);
        pushTick(n);
      end
    end
    if (stopMid) pushBus(1'b1, 32'hC, 32'h0);
    @(negedge HCLK);
    pendReg = 32'(pend);
    start   = ipendReads;
    tint    = 1'b1;
    k = 0;
    while (ipendReads == start && k < 300) begin
      @(negedge HCLK);
      k++;
    end
    if (ipendReads == start) begin
      checks++; errors++;
      $display("[TB] FAIL ipend_timeout: got no IPENDING read, expected one within 300 cycles");
    end
    tint = 1'b0;
    if (stopMid) begin
      cfg_stop = 1'b1;
      @(negedge HCLK);
      cfg_stop = 1'b0;
    end
    waitDrain(600);
  endtask

  task automatic doStop();
    pushBus(1'b1, 32'hC, 32'h0);
    @(negedge HCLK);
    cfg_stop = 1'b1;
    @(negedge HCLK);
    cfg_stop = 1'b0;
    waitDrain(200);
    checkOutput("stop_busy", 64'(busy), 64'd0);
  endtask

  task automatic badConfig(input string name);
    applyStimulus(64'h0, 1'b0, 1'b0);
    repeat (10) @(negedge HCLK);
    checkOutput({name, "_err"}, 64'(err), 64'd1);
    checkOutput({name, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic resetMidRearm();
    int k = 0;
    waitFixed = 0;
    pushBus(1'b0, 32'h8, 32'h0);
    @(negedge HCLK);
    pendReg = 32'h1;
    tint    = 1'b1;
    while (!(HTRANS == 2'b10 && HWRITE && HADDR == 32'h1C) && k < 300) begin
      @(negedge HCLK);
      k++;
    end
    if (k >= 300) begin
      checks++; errors++;
      $display("[TB] FAIL rearm_timeout: got no REARM address phase, expected one within 300 cycles");
    end
    HRESET = 1'b1;
    tint   = 1'b0;
    @(posedge HCLK); #1;
    checkOutput("rst_htrans", 64'(HTRANS), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_tick", 64'(tick), 64'd0);
    @(negedge HCLK);
    HRESET = 1'b0;
    expQ.delete();
    for (int n = 0; n < TIMERS; n++) mCmp[n] = '0;
    waitFixed = -1;
    repeat (3) @(negedge HCLK);
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    HRESET = 1'b1; cfg_start = 1'b0; cfg_stop = 1'b0; tint = 1'b0;
    cfg_prescale = '0; cfg_period = '0; cfg_enable = '0;
    for (int n = 0; n < TIMERS; n++) begin mCmp[n] = '0; mPeriod[n] = '0; end
    repeat (3) @(negedge HCLK);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_htrans", 64'(HTRANS), 64'd0);
    checkOutput("reset_hwrite", 64'(HWRITE), 64'd0);
    checkOutput("reset_tick", 64'(tick), 64'd0);
    checkOutput("reset_err", 64'(err), 64'd0);
    HRESET = 1'b0;
    @(negedge HCLK);

    $display("[TB] single channel, period 100, three services");
    mEnable = 3'b001; mPrescale = 32'd20; mPeriod[0] = 32'd100;
    applyStimulus(64'h0, 1'b1, 1'b0);
    waitDrain(300);
    checkOutput("cfg_busy", 64'(busy), 64'd1);
    repeat (3) serviceIrq(3'b001, 1'b0);

    $display("[TB] cfg_start while busy is ignored");
    @(negedge HCLK);
    cfg_enable = 3'b111; cfg_prescale = 32'd999;
    cfg_start = 1'b1;
    @(negedge HCLK);
    cfg_start = 1'b0;
    repeat (20) @(negedge HCLK);
    checkOutput("ignored_start_busy", 64'(busy), 64'd1);
    serviceIrq(3'b111, 1'b0);
    serviceIrq(3'b000, 1'b0);
    serviceIrq(3'b110, 1'b0);
    doStop();

    $display("[TB] channels 0 and 2, period 50, five wait states");
    waitFixed = 5;
    mEnable = 3'b101; mPrescale = 32'd40;
    mPeriod[0] = 32'd50; mPeriod[1] = 32'd0; mPeriod[2] = 32'd50;
    applyStimulus({$urandom, $urandom}, 1'b1, 1'b0);
    waitDrain(400);
    serviceIrq(3'b101, 1'b0);
    serviceIrq(3'b101, 1'b1);
    checkOutput("stop_mid_rearm_busy", 64'(busy), 64'd0);
    waitFixed = -1;

    $display("[TB] error response on IENABLE write");
    errAddr = 32'hC; errArm = 1'b1;
    applyStimulus(64'd1000, 1'b1, 1'b1);
    waitDrain(300);
    checkOutput("hresp_err", 64'(err), 64'd1);
    checkOutput("hresp_busy", 64'(busy), 64'd1);
    applyStimulus(64'd2000, 1'b1, 1'b0);
    checkOutput("restart_err", 64'(err), 64'd0);
    waitDrain(300);
    serviceIrq(3'b100, 1'b0);
    doStop();

    $display("[TB] rejected configurations");
    mEnable = 3'b001; mPeriod[0] = 32'd10; mPrescale = 32'd3;
    badConfig("bad_prescale3");
    mPrescale = 32'd14;
    badConfig("bad_prescale14");
    mPrescale = 32'd100; mEnable = 3'b000;
    badConfig("bad_enable");
    mEnable = 3'b011; mPeriod[0] = 32'd10; mPeriod[1] = 32'd0;
    badConfig("bad_period");

    $display("[TB] minimum prescale, 64-bit wrap, reset during rearm");
    mEnable = 3'b001; mPrescale = 32'd15; mPeriod[0] = 32'd100;
    applyStimulus(64'hFFFF_FFFF_FFFF_FFC0, 1'b1, 1'b0);
    waitDrain(300);
    checkOutput("min_prescale_err", 64'(err), 64'd0);
    serviceIrq(3'b001, 1'b0);
    resetMidRearm();

    $display("[TB] randomized configurations");
    for (int r = 0; r < 5; r++) begin
      waitMax = $urandom_range(0, 3);
      mEnable = TIMERS'($urandom_range(1, (1 << TIMERS) - 1));
      mPrescale = $urandom_range(15, 5000);
      for (int n = 0; n < TIMERS; n++)
        mPeriod[n] = mEnable[n] ? $urandom_range(1, 1000000) : 32'($urandom_range(0, 3));
      applyStimulus({$urandom, $urandom}, 1'b1, 1'b0);
      waitDrain(400);
      for (int s = 0; s < 3; s++) serviceIrq(TIMERS'($urandom_range(0, (1 << TIMERS) - 1)), 1'b0);
      doStop();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
